// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
// On-chip execution trace unit. Records one entry per retired instruction into a
// circular buffer, raises a registered halt request after a programmable retire
// count or on a PC match, and returns any captured entry by age-relative index.
module commit_trace_buffer #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               cfg_mode,
  input  logic [CNT_W-1:0]         cfg_limit,
  input  logic [PC_W-1:0]          cfg_pc_match,
  input  logic                     arm,
  input  logic                     resume,
  input  logic                     commit_valid,
  input  logic [PC_W-1:0]          commit_pc,
  input  logic [DATA_W-1:0]        commit_instr,
  input  logic                     commit_rf_we,
  input  logic [REG_AW-1:0]        commit_rf_addr,
  input  logic [DATA_W-1:0]        commit_rf_data,
  output logic                     halt,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   entry_count,
  output logic                     wrapped,
  output logic [CNT_W-1:0]         retired,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic                     rd_rf_we,
  output logic [REG_AW-1:0]        rd_rf_addr,
  output logic [DATA_W-1:0]        rd_rf_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_FREE  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_PC    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
    logic              rf_we;
    logic [REG_AW-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
  } rec_t;

  // Control state
  state_e           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   r_count;
  logic             r_wrapped;
  logic [CNT_W-1:0] r_retired;
  logic             r_halt;

  // Trace storage and readback register
  rec_t             r_mem [DEPTH];
  rec_t             r_rd;
  logic             r_rd_valid;

  // Next-state values
  state_e           w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W:0]   w_count_nxt;
  logic             w_wrapped_nxt;
  logic [CNT_W-1:0] w_retired_nxt;
  logic             w_capture;

  mode_e            w_mode;
  logic             w_arm;
  logic [CNT_W-1:0] w_retired_inc;
  rec_t             w_rec;
  logic [IDX_W-1:0] w_phys;
  logic             w_rd_hit;

  assign w_mode        = mode_e'(cfg_mode);
  assign w_arm         = arm && (w_mode != MODE_OFF);
  assign w_retired_inc = (r_retired == '1) ? r_retired : r_retired + 1'b1;
  assign w_rec         = '{pc: commit_pc, instr: commit_instr, rf_we: commit_rf_we,
                           rf_addr: commit_rf_addr, rf_data: commit_rf_data};

  // Oldest entry sits at the write pointer once the buffer has wrapped, else at slot 0.
  assign w_phys   = (r_wrapped ? r_ptr : '0) + rd_idx;
  assign w_rd_hit = ({1'b0, rd_idx} < r_count);

  // Next-state, capture decision and halt conditions
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_count_nxt   = r_count;
    w_wrapped_nxt = r_wrapped;
    w_retired_nxt = r_retired;
    w_capture     = 1'b0;

    if (w_arm) begin
      // arm overrides resume and discards a simultaneous commit
      w_state_nxt   = ST_CAPTURE;
      w_ptr_nxt     = '0;
      w_count_nxt   = '0;
      w_wrapped_nxt = 1'b0;
      w_retired_nxt = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: ;
        ST_CAPTURE: begin
          if (w_mode == MODE_OFF) begin
            w_state_nxt = ST_IDLE;
          end else if (w_mode == MODE_COUNT && r_retired >= cfg_limit) begin
            // limit already reached (e.g. cfg_limit==0): halt without capturing
            w_state_nxt = ST_HALTED;
          end else if (commit_valid) begin
            w_capture     = 1'b1;
            w_ptr_nxt     = r_ptr + 1'b1;
            w_retired_nxt = w_retired_inc;
            if (r_count == FULL_CNT) begin
              w_wrapped_nxt = 1'b1;
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
            if ((w_mode == MODE_COUNT && w_retired_inc == cfg_limit) ||
                (w_mode == MODE_PC && commit_pc == cfg_pc_match)) begin
              w_state_nxt = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          if (resume) begin
            w_state_nxt   = ST_CAPTURE;
            w_retired_nxt = '0;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control registers; halt is a registered copy of the HALTED decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_retired <= '0;
      r_halt    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_count   <= w_count_nxt;
      r_wrapped <= w_wrapped_nxt;
      r_retired <= w_retired_nxt;
      r_halt    <= (w_state_nxt == ST_HALTED);
    end
  end

  // Trace RAM write port
  // NOTE: storage has no reset; stale contents are masked by entry_count and rd_valid.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_ptr] <= w_rec;
    end
  end

  // Registered readback; a same-slot write in this cycle yields the old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_rd_hit) begin
      r_rd       <= r_mem[w_phys];
      r_rd_valid <= 1'b1;
    end else begin
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
    end
  end

  assign halt        = r_halt;
  assign state       = r_state;
  assign entry_count = r_count;
  assign wrapped     = r_wrapped;
  assign retired     = r_retired;
  assign rd_valid    = r_rd_valid;
  assign rd_pc       = r_rd.pc;
  assign rd_instr    = r_rd.instr;
  assign rd_rf_we    = r_rd.rf_we;
  assign rd_rf_addr  = r_rd.rf_addr;
  assign rd_rf_data  = r_rd.rf_data;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer
// Directed scenarios followed by randomized traffic, compared every cycle against a
// queue-based model of the trace: a list of the last DEPTH records since arm.
module tb_commit_trace_buffer;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam int S_IDLE = 0;
  localparam int S_CAP  = 1;
  localparam int S_HALT = 2;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] instr;
    logic              we;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [1:0]          cfg_mode;
  logic [CNT_W-1:0]    cfg_limit;
  logic [PC_W-1:0]     cfg_pc_match;
  logic                arm, resume, commit_valid;
  logic [PC_W-1:0]     commit_pc;
  logic [DATA_W-1:0]   commit_instr;
  logic                commit_rf_we;
  logic [REG_AW-1:0]   commit_rf_addr;
  logic [DATA_W-1:0]   commit_rf_data;
  logic                halt;
  logic [1:0]          state;
  logic [IDX_W:0]      entry_count;
  logic                wrapped;
  logic [CNT_W-1:0]    retired;
  logic [IDX_W-1:0]    rd_idx;
  logic                rd_valid;
  logic [PC_W-1:0]     rd_pc;
  logic [DATA_W-1:0]   rd_instr;
  logic                rd_rf_we;
  logic [REG_AW-1:0]   rd_rf_addr;
  logic [DATA_W-1:0]   rd_rf_data;

  commit_trace_buffer #(
    .PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_mode(cfg_mode), .cfg_limit(cfg_limit), .cfg_pc_match(cfg_pc_match),
    .arm(arm), .resume(resume),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_rf_we(commit_rf_we), .commit_rf_addr(commit_rf_addr),
    .commit_rf_data(commit_rf_data),
    .halt(halt), .state(state), .entry_count(entry_count), .wrapped(wrapped),
    .retired(retired), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_rf_we(rd_rf_we),
    .rd_rf_addr(rd_rf_addr), .rd_rf_data(rd_rf_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model
  int   m_state;
  rec_t trace[$];
  int   m_writes;
  int   m_retired;
  rec_t e_rd;
  logic e_rd_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state    = S_IDLE;
    trace.delete();
    m_writes   = 0;
    m_retired  = 0;
    e_rd       = '0;
    e_rd_valid = 1'b0;
  endfunction

  // One clock edge of behaviour, evaluated from the inputs present at that edge.
  function automatic void model_step();
    rec_t r;
    bit   stop;
    if (int'(rd_idx) < trace.size()) begin
      e_rd       = trace[rd_idx];
      e_rd_valid = 1'b1;
    end else begin
      e_rd       = '0;
      e_rd_valid = 1'b0;
    end
    if (arm && cfg_mode != 0) begin
      m_state   = S_CAP;
      trace.delete();
      m_writes  = 0;
      m_retired = 0;
      return;
    end
    if (m_state == S_HALT) begin
      if (resume) begin
        m_state   = S_CAP;
        m_retired = 0;
      end
      return;
    end
    if (m_state != S_CAP) return;
    if (cfg_mode == 0) begin
      m_state = S_IDLE;
      return;
    end
    if (cfg_mode == 2 && m_retired >= int'(cfg_limit)) begin
      m_state = S_HALT;
      return;
    end
    if (!commit_valid) return;
    r = '{pc: commit_pc, instr: commit_instr, we: commit_rf_we,
          addr: commit_rf_addr, data: commit_rf_data};
    trace.push_back(r);
    if (trace.size() > DEPTH) void'(trace.pop_front());
    m_writes++;
    if (m_retired < (1 << CNT_W) - 1) m_retired++;
    stop = (cfg_mode == 2 && m_retired == int'(cfg_limit)) ||
           (cfg_mode == 3 && commit_pc == cfg_pc_match);
    if (stop) m_state = S_HALT;
  endfunction

  task automatic compare_all();
    check("state",   state,       m_state);
    check("halt",    halt,        m_state == S_HALT);
    check("count",   entry_count, (trace.size() < DEPTH) ? trace.size() : DEPTH);
    check("wrapped", wrapped,     m_writes > DEPTH);
    check("retired", retired,     m_retired);
    check("rd_valid", rd_valid,   e_rd_valid);
    check("rd_pc",   rd_pc,       e_rd.pc);
    check("rd_instr", rd_instr,   e_rd.instr);
    check("rd_we",   rd_rf_we,    e_rd.we);
    check("rd_addr", rd_rf_addr,  e_rd.addr);
    check("rd_data", rd_rf_data,  e_rd.data);
  endtask

  // Advance one clock: model follows the edge, outputs are compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic do_commit(input logic [PC_W-1:0] pc);
    commit_valid   = 1'b1;
    commit_pc      = pc;
    commit_instr   = $urandom;
    commit_rf_we   = 1'($urandom_range(1));
    commit_rf_addr = REG_AW'($urandom);
    commit_rf_data = $urandom;
    cycle();
    commit_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_mode = 2'd0; cfg_limit = '0; cfg_pc_match = '0;
    arm = 1'b0; resume = 1'b0; commit_valid = 1'b0; commit_pc = '0;
    commit_instr = '0; commit_rf_we = 1'b0; commit_rf_addr = '0; commit_rf_data = '0;
    rd_idx = '0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // 1: reset in the middle of a capture
    cfg_mode = 2'd1;
    pulse_arm();
    for (int k = 0; k < 3; k++) do_commit(PC_W'(4 * k));
    rd_idx = '0;
    cycle();
    check("t1_pre_rd_valid", rd_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("t1_halt", halt, 1'b0);
    check("t1_state", state, 2'd0);
    check("t1_count", entry_count, 0);
    check("t1_rd_valid", rd_valid, 1'b0);
    cycle();
    reset = 1'b0;
    cycle();

    // 2: stop on count, limit 5, seven commits
    cfg_mode = 2'd2; cfg_limit = 16'd5;
    pulse_arm();
    for (int k = 0; k < 7; k++) begin
      do_commit(PC_W'(4 * k));
      if (k == 3) check("t2_no_halt_4th", halt, 1'b0);
      if (k == 4) check("t2_halt_5th", halt, 1'b1);
    end
    check("t2_count", entry_count, 5);
    check("t2_retired", retired, 5);
    rd_idx = 4'd4;
    cycle();
    check("t2_rd4_pc", rd_pc, 16);
    rd_idx = 4'd5;
    cycle();
    check("t2_rd5_valid", rd_valid, 1'b0);

    // 3: free run, 20 commits, then same-slot read/write and switch off
    cfg_mode = 2'd1;
    pulse_arm();
    for (int k = 0; k < 20; k++) do_commit(PC_W'(4 * k));
    check("t3_wrapped", wrapped, 1'b1);
    check("t3_count", entry_count, 16);
    rd_idx = 4'd15;
    cycle();
    check("t3_rd15_pc", rd_pc, 76);
    rd_idx = 4'd0;
    cycle();
    check("t3_rd0_pc", rd_pc, 16);
    do_commit(PC_W'(80));
    check("t3_rd0_old", rd_pc, 16);
    cycle();
    check("t3_rd0_new", rd_pc, 20);
    cfg_mode = 2'd0;
    cycle();
    check("t3_off_state", state, 2'd0);
    check("t3_off_count", entry_count, 16);

    // 4: stop on PC match, then resume
    cfg_mode = 2'd3; cfg_pc_match = 32'h20;
    pulse_arm();
    for (int k = 0; k <= 10; k++) begin
      do_commit(PC_W'(4 * k));
      if (k == 8) check("t4_halt", halt, 1'b1);
    end
    check("t4_count", entry_count, 9);
    resume = 1'b1;
    cycle();
    resume = 1'b0;
    check("t4_resume_state", state, 2'd1);
    check("t4_resume_halt", halt, 1'b0);
    do_commit(PC_W'(32'h100));
    check("t4_retired", retired, 1);
    check("t4_count2", entry_count, 10);
    rd_idx = 4'd9;
    cycle();
    check("t4_rd9_pc", rd_pc, 32'h100);

    // 5: arm with a commit; arm with resume while halted
    cfg_mode = 2'd1;
    arm = 1'b1;
    do_commit(PC_W'(32'h44));
    arm = 1'b0;
    check("t5_arm_commit_count", entry_count, 0);
    cfg_mode = 2'd2; cfg_limit = 16'd2;
    do_commit(PC_W'(8));
    do_commit(PC_W'(12));
    check("t5_halted", state, 2'd2);
    arm = 1'b1; resume = 1'b1;
    cycle();
    arm = 1'b0; resume = 1'b0;
    check("t5_state", state, 2'd1);
    check("t5_count", entry_count, 0);
    check("t5_retired", retired, 0);

    // 6: limit 0 halts right after entering capture, nothing stored
    cfg_limit = 16'd0;
    rd_idx = 4'd0;
    pulse_arm();
    check("t6_cap_state", state, 2'd1);
    do_commit(PC_W'(32'h60));
    check("t6_halt", halt, 1'b1);
    check("t6_count", entry_count, 0);
    cycle();
    check("t6_rd_valid", rd_valid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(399) == 0);
      arm    = ($urandom_range(29) == 0);
      resume = ($urandom_range(5) == 0);
      if ($urandom_range(39) == 0) cfg_mode = 2'($urandom);
      if ($urandom_range(19) == 0) cfg_limit = CNT_W'($urandom_range(20));
      if ($urandom_range(19) == 0) cfg_pc_match = PC_W'(4 * $urandom_range(15));
      commit_valid   = ($urandom_range(9) < 6);
      commit_pc      = PC_W'(4 * $urandom_range(15));
      commit_instr   = $urandom;
      commit_rf_we   = 1'($urandom_range(1));
      commit_rf_addr = REG_AW'($urandom);
      commit_rf_data = $urandom;
      rd_idx         = IDX_W'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
